// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester, transmitter-strobe and status bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int GW = $clog2(NUM_REQ);

    logic                   tick;
    logic [NUM_REQ-1:0]     req_valid;
    logic [8*NUM_REQ-1:0]   req_data;
    logic [NUM_REQ-1:0]     req_ready;
    logic [7:0]             tx_data_in;
    logic                   tx_load_data_reg;
    logic                   tx_byte_ready;
    logic                   tx_transfer_byte;
    logic [GW-1:0]          grant_id;
    logic                   busy;
    logic                   frame_done;

    modport master (
        output tick, req_valid, req_data,
        input  req_ready, tx_data_in, tx_load_data_reg, tx_byte_ready,
               tx_transfer_byte, grant_id, busy, frame_done
    );

    modport slave (
        input  tick, req_valid, req_data,
        output req_ready, tx_data_in, tx_load_data_reg, tx_byte_ready,
               tx_transfer_byte, grant_id, busy, frame_done
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter among NUM_REQ byte requesters
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int FRAME_TICKS  = 10,
    parameter int STROBE_TICKS = 2,
    parameter int GAP_TICKS    = 1
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.slave   bus
);
    localparam int GW    = $clog2(NUM_REQ);
    localparam int MAX_A = (FRAME_TICKS > STROBE_TICKS) ? FRAME_TICKS : STROBE_TICKS;
    localparam int MAX_T = (MAX_A > GAP_TICKS) ? MAX_A : GAP_TICKS;
    localparam int CW    = $clog2(MAX_T + 1);
    localparam int GAP_L = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

    localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_TICKS - 1);
    localparam logic [CW-1:0] FRAME_LAST  = CW'(FRAME_TICKS - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_L);

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_LOAD, S_BRDY, S_START, S_SEND, S_GAP
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [GW-1:0]  ptr;
    logic           found;
    logic [GW-1:0]  winner;
    int             idx;

    // First valid requester at or after the pointer, wrapping round.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= S_IDLE;
            cnt                  <= '0;
            ptr                  <= '0;
            bus.req_ready        <= '0;
            bus.tx_data_in       <= '0;
            bus.tx_load_data_reg <= 1'b0;
            bus.tx_byte_ready    <= 1'b0;
            bus.tx_transfer_byte <= 1'b0;
            bus.grant_id         <= '0;
            bus.busy             <= 1'b0;
            bus.frame_done       <= 1'b0;
        end else begin
            bus.req_ready  <= '0;
            bus.frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|bus.req_valid) begin
                        state    <= S_ARB;
                        bus.busy <= 1'b1;
                    end
                end
                S_ARB: begin
                    if (found) begin
                        bus.tx_data_in       <= bus.req_data[8*int'(winner) +: 8];
                        bus.grant_id         <= winner;
                        bus.req_ready        <= NUM_REQ'(1) << winner;
                        ptr                  <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
                        cnt                  <= '0;
                        bus.tx_load_data_reg <= 1'b1;
                        state                <= S_LOAD;
                    end else begin
                        // Requester withdrew before the grant; nothing consumed.
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (bus.tick) begin
                        if (cnt == STROBE_LAST) begin
                            cnt                  <= '0;
                            bus.tx_load_data_reg <= 1'b0;
                            bus.tx_byte_ready    <= 1'b1;
                            state                <= S_BRDY;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_BRDY: begin
                    if (bus.tick) begin
                        if (cnt == STROBE_LAST) begin
                            cnt                  <= '0;
                            bus.tx_byte_ready    <= 1'b0;
                            bus.tx_transfer_byte <= 1'b1;
                            state                <= S_START;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_START: begin
                    if (bus.tick) begin
                        if (cnt == STROBE_LAST) begin
                            cnt                  <= '0;
                            bus.tx_transfer_byte <= 1'b0;
                            state                <= S_SEND;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (bus.tick) begin
                        if (cnt == FRAME_LAST) begin
                            cnt            <= '0;
                            bus.frame_done <= 1'b1;
                            if (GAP_TICKS != 0) begin
                                state <= S_GAP;
                            end else if (|bus.req_valid) begin
                                state <= S_ARB;
                            end else begin
                                state    <= S_IDLE;
                                bus.busy <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (bus.tick) begin
                        if (cnt == GAP_LAST) begin
                            cnt <= '0;
                            if (|bus.req_valid) begin
                                state <= S_ARB;
                            end else begin
                                state    <= S_IDLE;
                                bus.busy <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
